// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
// Shared types and helpers for the data-memory responder:
//   mem_size_t  - access size encoding carried on req_size (BYTE/HALF/WORD)
//   mem_resp_t  - one response record {tag, data, is_store, err}
//   rob_age     - distance of a ROB tag from the current ROB head (mod 32)
//   is_younger  - true when a tag is strictly younger than a reference tag
//   extend_load - sign/zero extension of a right-aligned load value
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] data;
    logic        is_store;
    logic        err;
  } mem_resp_t;

  // The 5-bit subtraction wraps naturally, giving age modulo 32.
  function automatic logic [4:0] rob_age(input logic [4:0] tag, input logic [4:0] head);
    return tag - head;
  endfunction

  function automatic logic is_younger(input logic [4:0] tag, input logic [4:0] ref_tag,
                                      input logic [4:0] head);
    return rob_age(tag, head) > rob_age(ref_tag, head);
  endfunction

  // Unknown size encodings fall through to a full-word result.
  function automatic logic [31:0] extend_load(input logic [31:0] shifted, input mem_size_t size,
                                              input logic zero_ext);
    logic [31:0] result;
    case (size)
      BYTE:    result = zero_ext ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      HALF:    result = zero_ext ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/dmem_responder_resp_fifo.sv
// resp_fifo
// Compacting response FIFO. Entry 0 is always the head; any entry can be
// removed in place through the squash mask and the survivors slide down
// toward the head in the same cycle, preserving order.
// Ports:
//   clk, reset_n        - clock, asynchronous active-low reset
//   push, push_data     - append one response at the tail
//   pop                 - remove the head entry
//   squash[DEPTH]       - per-entry invalidate mask (applied with pop/push)
//   entries[DEPTH]      - registered entry contents (zero when unused)
//   entry_valid[DEPTH]  - per-entry valid bits
//   count               - number of valid entries
module resp_fifo
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  mem_resp_t             push_data,
  input  logic                  pop,
  input  logic [DEPTH-1:0]      squash,
  output mem_resp_t [DEPTH-1:0] entries,
  output logic [DEPTH-1:0]      entry_valid,
  output logic [CNT_W-1:0]      count
);

  mem_resp_t [DEPTH-1:0] ent_q, ent_d;
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  int                    fill;

  // Rebuild the whole entry list each cycle: survivors are packed from the
  // head, then the pushed record lands right behind them. Unused slots are
  // cleared so the head registers read as zero whenever the FIFO is empty.
  always_comb begin
    ent_d = '0;
    vld_d = '0;
    fill  = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && !squash[i] && !(pop && i == 0)) begin
        ent_d[fill] = ent_q[i];
        vld_d[fill] = 1'b1;
        fill        = fill + 1;
      end
    end
    if (push && fill < DEPTH) begin
      ent_d[fill] = push_data;
      vld_d[fill] = 1'b1;
      fill        = fill + 1;
    end
    cnt_d = CNT_W'(fill);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent_q <= '0;
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign entries     = ent_q;
  assign entry_valid = vld_q;
  assign count       = cnt_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Memory-side endpoint of the LSQ request channel. Accepts one load/store per
// cycle, performs byte/half/word access on an internal word array, and returns
// tagged responses after LATENCY cycles through a compacting response FIFO.
// Loads younger than a mispredicting branch are squashed wherever they sit.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN
//   defined   - misaligned half/word flags resp_err, suppresses stores and
//               returns 0 for loads
//   undefined - resp_err is 0 and offsets are forced to natural alignment
// Ports:
//   clk, reset_n                 - clock, asynchronous active-low reset
//   req_valid/req_ready          - request handshake
//   req_we, req_addr, req_wdata  - store flag, byte address, LSB-aligned data
//   req_size, req_unsigned       - access size, zero-extend loads
//   req_rob_tag                  - ROB tag echoed on the response
//   rob_head                     - ROB head used as the age origin
//   mispredict, mispredict_tag   - flush pulse and the branch tag
//   resp_valid/resp_ready        - response handshake
//   resp_data, resp_rob_tag      - load data (0 for stores), echoed tag
//   resp_is_store, resp_err      - store completion, misaligned access
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int RESP_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [4:0]  req_rob_tag,
  input  logic [4:0]  rob_head,
  input  logic        mispredict,
  input  logic [4:0]  mispredict_tag,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rob_tag,
  output logic        resp_is_store,
  output logic        resp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  logic [31:0]            mem [DEPTH_WORDS];
  logic [IDX_W-1:0]       idx;
  mem_size_t              size;
  logic [1:0]             offset;
  logic [3:0]             byte_en;
  logic [31:0]            wdata_rep;
  logic                   misaligned;
  logic [31:0]            load_data;
  logic                   accept;
  logic                   store_en;
  logic                   req_squashed;
  mem_resp_t              req_resp;
  logic                   ready_en;
  int                     occupancy;

  logic [LATENCY-1:0]     stg_valid;
  mem_resp_t              stg [LATENCY];
  logic [LATENCY-1:0]     stg_squash;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic [RESP_DEPTH-1:0]  fifo_squash;
  mem_resp_t [RESP_DEPTH-1:0] fifo_entries;
  logic [RESP_DEPTH-1:0]  fifo_valid;
  logic [CNT_W-1:0]       fifo_count;

  logic                   unused_addr;

  assign idx         = req_addr[IDX_W+1:2];
  assign size        = mem_size_t'(req_size);
  assign unused_addr = ^{req_addr[31:IDX_W+2]};

  // Lane selection and data replication. Half accesses always use the
  // naturally aligned half selected by addr[1]; word accesses ignore the
  // low address bits. With the checker enabled, offending accesses are
  // flagged instead of being silently realigned.
  always_comb begin
    offset     = 2'b00;
    byte_en    = 4'b1111;
    wdata_rep  = req_wdata;
    misaligned = 1'b0;
    case (size)
      BYTE: begin
        offset    = req_addr[1:0];
        byte_en   = 4'b0001 << req_addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      HALF: begin
        offset    = {req_addr[1], 1'b0};
        byte_en   = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: begin
        offset = 2'b00;
      end
    endcase
`ifdef DMEM_MISALIGN_CHECK_EN
    misaligned = (req_size == 2'd1 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif
  end

  // Loads read the array combinationally in the acceptance cycle, so a
  // store written at the previous edge is already visible.
  always_comb begin
    load_data = extend_load(mem[idx] >> {offset, 3'b000}, size, req_unsigned);
    if (misaligned) begin
      load_data = '0;
    end
  end

  assign accept       = req_valid && req_ready;
  assign store_en     = accept && req_we && !misaligned;
  assign req_squashed = mispredict && !req_we && is_younger(req_rob_tag, mispredict_tag, rob_head);

  always_comb begin
    req_resp          = '0;
    req_resp.tag      = req_rob_tag;
    req_resp.data     = req_we ? 32'h0 : load_data;
    req_resp.is_store = req_we;
    req_resp.err      = misaligned;
  end

  // The array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
      end
    end
  end

  // Flush targets: loads strictly younger than the mispredicting branch.
  always_comb begin
    stg_squash = '0;
    for (int i = 0; i < LATENCY; i++) begin
      stg_squash[i] = mispredict && stg_valid[i] && !stg[i].is_store &&
                      is_younger(stg[i].tag, mispredict_tag, rob_head);
    end
  end

  always_comb begin
    fifo_squash = '0;
    for (int i = 0; i < RESP_DEPTH; i++) begin
      fifo_squash[i] = mispredict && fifo_valid[i] && !fifo_entries[i].is_store &&
                       is_younger(fifo_entries[i].tag, mispredict_tag, rob_head);
    end
  end

  // Fixed-latency pipeline; squashed stages simply lose their valid bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        stg[i] <= '0;
      end
    end else begin
      stg_valid[0] <= accept && !req_squashed;
      stg[0]       <= req_resp;
      for (int i = 1; i < LATENCY; i++) begin
        stg_valid[i] <= stg_valid[i-1] && !stg_squash[i-1];
        stg[i]       <= stg[i-1];
      end
    end
  end

  assign fifo_push = stg_valid[LATENCY-1] && !stg_squash[LATENCY-1];
  assign fifo_pop  = resp_valid && resp_ready;

  resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .CNT_W (CNT_W)
  ) u_resp_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (fifo_push),
    .push_data   (stg[LATENCY-1]),
    .pop         (fifo_pop),
    .squash      (fifo_squash),
    .entries     (fifo_entries),
    .entry_valid (fifo_valid),
    .count       (fifo_count)
  );

  // Holds req_ready low through reset and until the first edge after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // Counting in-flight stages together with buffered entries guarantees every
  // accepted request has a FIFO slot waiting for it, so the FIFO never overflows.
  always_comb begin
    occupancy = int'(fifo_count);
    for (int i = 0; i < LATENCY; i++) begin
      occupancy = occupancy + int'(stg_valid[i]);
    end
  end

  assign req_ready = ready_en && (occupancy < RESP_DEPTH);

  // Head entry registers drive the response directly; they are zero when empty.
  assign resp_valid    = fifo_valid[0];
  assign resp_data     = fifo_entries[0].data;
  assign resp_rob_tag  = fifo_entries[0].tag;
  assign resp_is_store = fifo_entries[0].is_store;
  assign resp_err      = fifo_entries[0].err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Directed bench for dmem_responder with default parameters (LATENCY=2,
// RESP_DEPTH=4). Inputs change 1 ns after the rising edge; responses are
// recorded on the falling edge when the handshake completes.
// Honours DMEM_MISALIGN_CHECK_EN for the misalignment expectations.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [4:0]  req_rob_tag;
  logic [4:0]  rob_head;
  logic        mispredict;
  logic [4:0]  mispredict_tag;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rob_tag;
  logic        resp_is_store;
  logic        resp_err;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [38:0] cap[$];

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_rob_tag    (req_rob_tag),
    .rob_head       (rob_head),
    .mispredict     (mispredict),
    .mispredict_tag (mispredict_tag),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data),
    .resp_rob_tag   (resp_rob_tag),
    .resp_is_store  (resp_is_store),
    .resp_err       (resp_err)
  );

  // Records every completed response as {tag, data, is_store, err}.
  always @(negedge clk) begin
    if (reset_n && resp_valid && resp_ready) begin
      cap.push_back({resp_rob_tag, resp_data, resp_is_store, resp_err});
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] aborting");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns, input logic [4:0] tag);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_unsigned = uns;
    req_rob_tag  = tag;
    for (int g = 0; g < 64 && !req_ready; g++) cyc();
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL issue_accept tag %0d: req_ready got %b expected 1", tag, req_ready);
    end
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int n, input int budget);
    for (int g = 0; g < budget && cap.size() < n; g++) cyc();
    n_cmp++;
    if (cap.size() < n) begin
      n_fail++;
      $display("[TB] FAIL wait_resp: got %0d responses expected %0d", cap.size(), n);
    end
  endtask

  task automatic test_reset();
    $display("[TB] running test_reset");
    repeat (2) cyc();
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_req_ready: got %b expected 0", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_resp_valid: got %b expected 0", resp_valid); end
    n_cmp++; if (resp_data !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_resp_data: got %h expected 0", resp_data); end
    n_cmp++; if (resp_rob_tag !== 5'h0) begin n_fail++; $display("[TB] FAIL rst_resp_tag: got %h expected 0", resp_rob_tag); end
    n_cmp++; if (resp_is_store !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_is_store: got %b expected 0", resp_is_store); end
    n_cmp++; if (resp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_resp_err: got %b expected 0", resp_err); end
    reset_n = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rel_req_ready_early: got %b expected 0", req_ready); end
    cyc();
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rel_req_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_store_load();
    $display("[TB] running test_store_load");
    resp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hDEADBEEF;
    req_size = 2'd2; req_unsigned = 1'b0; req_rob_tag = 5'd1;
    cyc();
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL sl_valid_e1: got %b expected 0", resp_valid); end
    req_we = 1'b0; req_wdata = 32'h0; req_rob_tag = 5'd2;
    cyc();
    req_valid = 1'b0;
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL sl_valid_e2: got %b expected 0", resp_valid); end
    cyc();
    n_cmp++; if ({resp_valid, resp_rob_tag, resp_data, resp_is_store, resp_err} !== {1'b1, 5'd1, 32'h0, 1'b1, 1'b0})
      begin n_fail++; $display("[TB] FAIL sl_store_resp: got %b/%h/%h/%b expected 1/01/00000000/1", resp_valid, resp_rob_tag, resp_data, resp_is_store); end
    cyc();
    n_cmp++; if ({resp_valid, resp_rob_tag, resp_data, resp_is_store, resp_err} !== {1'b1, 5'd2, 32'hDEADBEEF, 1'b0, 1'b0})
      begin n_fail++; $display("[TB] FAIL sl_load_resp: got %b/%h/%h/%b expected 1/02/deadbeef/0", resp_valid, resp_rob_tag, resp_data, resp_is_store); end
    cyc();
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL sl_drained: got %b expected 0", resp_valid); end
  endtask

  task automatic test_extend();
    logic [38:0] exp_rsp [7];
    $display("[TB] running test_extend");
    cap.delete();
    exp_rsp[0] = {5'd4,  32'h00000000, 1'b1, 1'b0};
    exp_rsp[1] = {5'd5,  32'h00000001, 1'b0, 1'b0};
    exp_rsp[2] = {5'd6,  32'hFFFFFF80, 1'b0, 1'b0};
    exp_rsp[3] = {5'd7,  32'h00000080, 1'b0, 1'b0};
    exp_rsp[4] = {5'd8,  32'hFFFF80F0, 1'b0, 1'b0};
    exp_rsp[5] = {5'd9,  32'h000080F0, 1'b0, 1'b0};
    exp_rsp[6] = {5'd10, 32'h00007F01, 1'b0, 1'b0};
    issue(1'b1, 32'h10, 32'h80F07F01, 2'd2, 1'b0, 5'd4);
    issue(1'b0, 32'h10, 32'h0, 2'd0, 1'b0, 5'd5);
    issue(1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 5'd6);
    issue(1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 5'd7);
    issue(1'b0, 32'h12, 32'h0, 2'd1, 1'b0, 5'd8);
    issue(1'b0, 32'h12, 32'h0, 2'd1, 1'b1, 5'd9);
    issue(1'b0, 32'h10, 32'h0, 2'd1, 1'b0, 5'd10);
    wait_resp(7, 30);
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (cap.size() <= i || cap[i] !== exp_rsp[i]) begin
        n_fail++;
        $display("[TB] FAIL ext_resp%0d: got %h expected %h", i, (cap.size() > i) ? cap[i] : 39'h0, exp_rsp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    $display("[TB] running test_backpressure");
    cap.delete();
    resp_ready = 1'b0;
    acc = 0;
    req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_unsigned = 1'b0; req_wdata = 32'h0;
    for (int c = 0; c < 10; c++) begin
      req_valid = 1'b1;
      req_rob_tag = 5'(16 + acc);
      if (req_ready) acc++;
      cyc();
    end
    n_cmp++; if (acc !== 4) begin n_fail++; $display("[TB] FAIL bp_accepted: got %0d expected 4", acc); end
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_req_ready: got %b expected 0", req_ready); end
    n_cmp++; if (resp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_resp_valid: got %b expected 1", resp_valid); end
    n_cmp++; if (cap.size() !== 0) begin n_fail++; $display("[TB] FAIL bp_no_pop: got %0d expected 0", cap.size()); end
    resp_ready = 1'b1;
    for (int c = 0; c < 30 && acc < 6; c++) begin
      req_valid = 1'b1;
      req_rob_tag = 5'(16 + acc);
      if (req_ready) acc++;
      cyc();
    end
    req_valid = 1'b0;
    wait_resp(6, 30);
    repeat (3) cyc();
    n_cmp++; if (cap.size() !== 6) begin n_fail++; $display("[TB] FAIL bp_count: got %0d expected 6", cap.size()); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (cap.size() <= i || cap[i] !== {5'(16 + i), 32'h80F07F01, 1'b0, 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL bp_order%0d: got %h expected %h", i, (cap.size() > i) ? cap[i] : 39'h0, {5'(16 + i), 32'h80F07F01, 1'b0, 1'b0});
      end
    end
  endtask

  task automatic test_flush();
    $display("[TB] running test_flush");
    cap.delete();
    resp_ready = 1'b0;
    rob_head = 5'd0;
    issue(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 5'd3);
    issue(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 5'd5);
    issue(1'b1, 32'h80, 32'h12345678, 2'd2, 1'b0, 5'd6);
    issue(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 5'd7);
    mispredict = 1'b1; mispredict_tag = 5'd4;
    cyc();
    mispredict = 1'b0;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL fl_ready_after: got %b expected 1", req_ready); end
    resp_ready = 1'b1;
    wait_resp(2, 20);
    repeat (5) cyc();
    n_cmp++; if (cap.size() !== 2) begin n_fail++; $display("[TB] FAIL fl_count: got %0d expected 2", cap.size()); end
    n_cmp++; if (cap.size() < 1 || cap[0] !== {5'd3, 32'hDEADBEEF, 1'b0, 1'b0}) begin n_fail++; $display("[TB] FAIL fl_resp0: got %h expected %h", (cap.size() > 0) ? cap[0] : 39'h0, {5'd3, 32'hDEADBEEF, 1'b0, 1'b0}); end
    n_cmp++; if (cap.size() < 2 || cap[1] !== {5'd6, 32'h0, 1'b1, 1'b0}) begin n_fail++; $display("[TB] FAIL fl_resp1: got %h expected %h", (cap.size() > 1) ? cap[1] : 39'h0, {5'd6, 32'h0, 1'b1, 1'b0}); end

    // Requests accepted during the mispredict cycle, including wrap-around ages.
    cap.delete();
    mispredict = 1'b1; mispredict_tag = 5'd4; rob_head = 5'd0;
    issue(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 5'd9);
    mispredict = 1'b0; repeat (4) cyc();
    mispredict = 1'b1;
    issue(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 5'd2);
    mispredict = 1'b0; repeat (4) cyc();
    mispredict = 1'b1; mispredict_tag = 5'd31; rob_head = 5'd30;
    issue(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 5'd1);
    mispredict = 1'b0; repeat (4) cyc();
    mispredict = 1'b1;
    issue(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 5'd30);
    mispredict = 1'b0;
    wait_resp(2, 20);
    repeat (4) cyc();
    rob_head = 5'd0; mispredict_tag = 5'd0;
    n_cmp++; if (cap.size() !== 2) begin n_fail++; $display("[TB] FAIL fl_req_count: got %0d expected 2", cap.size()); end
    n_cmp++; if (cap.size() < 1 || cap[0] !== {5'd2, 32'hDEADBEEF, 1'b0, 1'b0}) begin n_fail++; $display("[TB] FAIL fl_req_keep_old: got %h expected %h", (cap.size() > 0) ? cap[0] : 39'h0, {5'd2, 32'hDEADBEEF, 1'b0, 1'b0}); end
    n_cmp++; if (cap.size() < 2 || cap[1] !== {5'd30, 32'hDEADBEEF, 1'b0, 1'b0}) begin n_fail++; $display("[TB] FAIL fl_req_keep_wrap: got %h expected %h", (cap.size() > 1) ? cap[1] : 39'h0, {5'd30, 32'hDEADBEEF, 1'b0, 1'b0}); end
  endtask

  task automatic test_reset_midway();
    $display("[TB] running test_reset_midway");
    cap.delete();
    resp_ready = 1'b0;
    issue(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 5'd11);
    issue(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 5'd12);
    issue(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 5'd13);
    repeat (3) cyc();
    n_cmp++; if (resp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL mr_pending: got %b expected 1", resp_valid); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mr_valid_drop: got %b expected 0", resp_valid); end
    n_cmp++; if (resp_data !== 32'h0) begin n_fail++; $display("[TB] FAIL mr_data_clear: got %h expected 0", resp_data); end
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mr_req_ready: got %b expected 0", req_ready); end
    cyc();
    reset_n = 1'b1;
    resp_ready = 1'b1;
    repeat (10) cyc();
    n_cmp++; if (cap.size() !== 0) begin n_fail++; $display("[TB] FAIL mr_no_resp: got %0d expected 0", cap.size()); end
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mr_ready_back: got %b expected 1", req_ready); end
  endtask

  task automatic test_misalign();
    logic [38:0] exp_rsp [5];
    $display("[TB] running test_misalign");
    cap.delete();
    resp_ready = 1'b1;
    exp_rsp[0] = {5'd1, 32'h0, 1'b1, 1'b0};
`ifdef DMEM_MISALIGN_CHECK_EN
    exp_rsp[1] = {5'd2, 32'h0, 1'b1, 1'b1};
    exp_rsp[2] = {5'd3, 32'h11223344, 1'b0, 1'b0};
    exp_rsp[3] = {5'd4, 32'h00001122, 1'b0, 1'b0};
    exp_rsp[4] = {5'd5, 32'h0, 1'b0, 1'b1};
`else
    exp_rsp[1] = {5'd2, 32'h0, 1'b1, 1'b0};
    exp_rsp[2] = {5'd3, 32'h1122AABB, 1'b0, 1'b0};
    exp_rsp[3] = {5'd4, 32'h00001122, 1'b0, 1'b0};
    exp_rsp[4] = {5'd5, 32'h1122AABB, 1'b0, 1'b0};
`endif
    issue(1'b1, 32'h20, 32'h11223344, 2'd2, 1'b0, 5'd1);
    issue(1'b1, 32'h21, 32'h0000AABB, 2'd1, 1'b0, 5'd2);
    issue(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 5'd3);
    issue(1'b0, 32'h22, 32'h0, 2'd1, 1'b0, 5'd4);
    issue(1'b0, 32'h22, 32'h0, 2'd2, 1'b0, 5'd5);
    wait_resp(5, 30);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (cap.size() <= i || cap[i] !== exp_rsp[i]) begin
        n_fail++;
        $display("[TB] FAIL mis_resp%0d: got %h expected %h", i, (cap.size() > i) ? cap[i] : 39'h0, exp_rsp[i]);
      end
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    req_valid      = 1'b0;
    req_we         = 1'b0;
    req_addr       = 32'h0;
    req_wdata      = 32'h0;
    req_size       = 2'd0;
    req_unsigned   = 1'b0;
    req_rob_tag    = 5'd0;
    rob_head       = 5'd0;
    mispredict     = 1'b0;
    mispredict_tag = 5'd0;
    resp_ready     = 1'b1;
    test_reset();
    test_store_load();
    test_extend();
    test_backpressure();
    test_flush();
    test_reset_midway();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder at the far end of the LSQ memory-request channel. It accepts one load or store request per cycle over a valid/ready handshake and performs byte/half/word access on an internal word array. It returns a tagged response after a fixed pipeline latency through a small response FIFO. Load responses younger than a branch mispredict are squashed. This block is the memory-side endpoint the core's load/store path drives.

## Interface
- `DEPTH_WORDS`, 1024: word-array depth; index = `req_addr[$clog2(DEPTH_WORDS)+1:2]`.
- `LATENCY`, 2: cycles from request acceptance to response eligibility (≥1).
- `RESP_DEPTH`, 4: response FIFO depth; also the bound on in-flight plus buffered requests.

- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, LSB-aligned.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word.
- `req_unsigned` in 1: zero-extend load (LBU/LHU).
- `req_rob_tag` in 5: ROB tag of the request.
- `rob_head` in 5: current ROB head, used for age compare.
- `mispredict` in 1: flush pulse.
- `mispredict_tag` in 5: ROB tag of the mispredicting branch.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_data` out 32: extended load data; 0 for stores.
- `resp_rob_tag` out 5: tag echoed from the request.
- `resp_is_store` out 1: response belongs to a store (drives store completion).
- `resp_err` out 1: misaligned access (see Configuration).

## Operation
- Accept condition: `req_valid && req_ready`. `req_ready = occupancy < RESP_DEPTH`, where occupancy = valid pipeline stages + FIFO entries.
- **Store:**
  - Performs its byte-enabled write in the acceptance cycle.
  - Byte writes lane `addr[1:0]`; half writes lanes `{addr[1],0}`; word writes all lanes. Data is replicated into the selected lanes.
  - Enters the pipeline as a store response: data 0, `resp_is_store=1`.
- **Load:**
  - Reads the word in the acceptance cycle.
  - Shifts right by `8*addr[1:0]` and sign- or zero-extends per `req_size`/`req_unsigned`.
  - The result travels down the pipeline.
- A load accepted the cycle after a store to the same word returns the stored data.
- Pipeline: `LATENCY`-stage shift register of {valid, tag, data, is_store, err}. The stage at the end pushes into the FIFO. Occupancy accounting guarantees the FIFO never overflows.
- **Flush:**
  - On `mispredict`, age(t) = (t − `rob_head`) mod 32.
  - Every pipeline stage or FIFO entry that is a load with age(tag) > age(`mispredict_tag`) is invalidated.
  - Stores are never squashed.
  - The FIFO compacts invalidated entries. Occupancy drops the same cycle, so `req_ready` may rise the next cycle.
- A request accepted in the mispredict cycle is subject to the same age test; a younger load is silently dropped.
- FIFO full with `resp_ready=0`: the pipeline keeps advancing, because occupancy gating prevents overflow. `req_ready` stays 0 until a pop or a flush.

## Timing
- Reset (`reset_n` low, async):
  - `req_ready=0`.
  - `resp_valid=0`, `resp_data=0`, `resp_rob_tag=0`, `resp_is_store=0`, `resp_err=0`.
  - Pipeline and FIFO are emptied; array contents are unspecified (not cleared).
  - `req_ready=1` from the first clock edge after release.
- Request accepted at edge N → `resp_valid=1` earliest after edge N+LATENCY. Back-to-back accepts produce back-to-back responses when `resp_ready=1`.
- Responses are delivered in acceptance order.
- Response outputs are registered at the FIFO head. They are held stable while `resp_valid && !resp_ready`.
- Pop occurs when `resp_valid && resp_ready`. A simultaneous push and pop on a full FIFO is legal.
- Reset asserted mid-operation drops all in-flight responses immediately.

## Configuration
- `DMEM_MISALIGN_CHECK_EN` defined:
  - Half with `addr[0]=1`, or word with `addr[1:0]≠0`, sets `resp_err=1`.
  - A misaligned store is suppressed (no array write).
  - A misaligned load returns data 0.
- Undefined:
  - `resp_err` is tied to 0.
  - Misaligned offsets are forced to natural alignment: half uses `addr[1]`, word ignores `addr[1:0]`.

## Structure
- Add to `types_pkg`:
  - `mem_size_t` enum (BYTE/HALF/WORD).
  - `mem_resp_t` struct {tag, data, is_store, err}.
  - Function `rob_age(tag, head)`.
- Sub-module `resp_fifo`: parameterised depth, push/pop, per-entry squash mask input, occupancy output.

## Test plan
- Word store 0xDEADBEEF @0x40 at cycle 1, LW @0x40 at cycle 2 → load response 0xDEADBEEF at cycle 2+LATENCY; store response (is_store=1, tag echoed) at cycle 1+LATENCY.
- After SW 0x80F0_7F01 @0x10:
  - LB @0x10 → 0x00000001.
  - LB @0x13 → 0xFFFFFF80.
  - LBU @0x13 → 0x00000080.
  - LH @0x12 → 0xFFFF80F0.
- `resp_ready=0`, issue 6 loads → exactly `RESP_DEPTH`=4 accepted and `req_ready=0`; raise `resp_ready` → 4 responses in order, then the remaining 2 are accepted.
- head=0, in-flight loads tags 3,5,7 plus store tag 6; mispredict_tag=4 → only tag 3 load and tag 6 store respond.
- `reset_n` pulled low with 3 responses pending → `resp_valid=0` immediately; no responses after release.
- SH @0x21: with `DMEM_MISALIGN_CHECK_EN`, `resp_err=1` and memory is unchanged; without it, the write goes to lanes 0–1 of word 0x20 and `resp_err=0`.
